// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for the in-order MIPS pipeline: stall and forward-select generation.
// Optional HAZ_MD_BUSY_EN adds the multiply/divide busy interlock (md_busy, d_md_use).
module hazard_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int RAW    = 5,
  parameter int TW     = 2,
  localparam int SW    = $clog2(NSTAGE + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 d_valid,
  input  logic [RAW-1:0]       d_a1,
  input  logic [RAW-1:0]       d_a2,
  input  logic [RAW-1:0]       d_a3,
  input  logic                 d_rs_use,
  input  logic                 d_rt_use,
  input  logic [TW-1:0]        d_tuse_rs,
  input  logic [TW-1:0]        d_tuse_rt,
  input  logic [TW-1:0]        d_tnew,
  input  logic                 flush,
`ifdef HAZ_MD_BUSY_EN
  input  logic                 md_busy,
  input  logic                 d_md_use,
`endif
  output logic                 stall,
  output logic [SW-1:0]        fwd_rs,
  output logic [SW-1:0]        fwd_rt,
  output logic [NSTAGE*RAW-1:0] stg_a3,
  output logic [NSTAGE*TW-1:0]  stg_tnew
);

  // Index 0 holds stage 1 (E); index NSTAGE-1 holds the oldest tracked stage.
  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [RAW-1:0]    a3_q   [NSTAGE];
  logic [RAW-1:0]    a3_d   [NSTAGE];
  logic [TW-1:0]     tnew_q [NSTAGE];
  logic [TW-1:0]     tnew_d [NSTAGE];

  logic          rsHit, rtHit;
  logic [SW-1:0] rsSel, rtSel;
  logic [TW-1:0] rsTnew, rtTnew;
  logic          regStall, mdStall, insert;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        a3_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < NSTAGE; k++) begin
        a3_q[k]   <= a3_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    rsHit  = 1'b0;
    rtHit  = 1'b0;
    rsSel  = '0;
    rtSel  = '0;
    rsTnew = '0;
    rtTnew = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (d_rs_use && valid_q[k] && (a3_q[k] == d_a1) && (d_a1 != '0)) begin
        rsHit  = 1'b1;
        rsSel  = SW'(k + 1);
        rsTnew = tnew_q[k];
      end
      if (d_rt_use && valid_q[k] && (a3_q[k] == d_a2) && (d_a2 != '0)) begin
        rtHit  = 1'b1;
        rtSel  = SW'(k + 1);
        rtTnew = tnew_q[k];
      end
    end
  end

  always_comb begin
    regStall = d_valid & ((rsHit & (rsTnew > d_tuse_rs)) | (rtHit & (rtTnew > d_tuse_rt)));
`ifdef HAZ_MD_BUSY_EN
    mdStall  = d_valid & d_md_use & md_busy;
`else
    mdStall  = 1'b0;
`endif
    stall  = regStall | mdStall;
    fwd_rs = (rsHit && (rsTnew == '0)) ? rsSel : '0;
    fwd_rt = (rtHit && (rtTnew == '0)) ? rtSel : '0;
  end

  // Stage 1 takes the D instruction or a bubble; later stages shift with saturating tnew.
  always_comb begin
    insert     = d_valid & ~stall & ~flush;
    valid_d    = '0;
    valid_d[0] = insert & (d_a3 != '0);
    a3_d[0]    = insert ? d_a3 : '0;
    tnew_d[0]  = insert ? d_tnew : '0;
    for (int k = 1; k < NSTAGE; k++) begin
      valid_d[k] = valid_q[k-1];
      a3_d[k]    = a3_q[k-1];
      tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
    end
  end

  always_comb begin
    stg_a3   = '0;
    stg_tnew = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      stg_a3[k*RAW +: RAW] = a3_q[k];
      stg_tnew[k*TW +: TW] = tnew_q[k];
    end
  end

endmodule
